// File: rtl/pc_sequencer.sv
// pc_sequencer -- program-counter sequencer for a single-cycle LEGv8-style datapath.
//
// Selects the next PC from the encoded branch mode. The options are sequential,
// PC-relative (B, CBZ, CBNZ, BL), or register-indirect (BR). It also produces
// the link-register write-back for BL and keeps a sticky flag for misaligned
// indirect targets.
//
// Optional feature macro: PC_RAS_EN
//   When defined, a circular return-address stack of RAS_DEPTH entries is added.
//   BL pushes onto it and mode 6 (RET) pops from it. Without the macro,
//   mode 6 behaves as SEQ.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   stall        in   hold PC / link / stack and suppress flag updates
//   br_mode      in   [2:0] 0 SEQ,1 B,2 CBZ,3 CBNZ,4 BR,5 BL,6 RET,7 reserved
//   z_flag       in   ALU zero flag of the current instruction
//   br_offset    in   [OFFSET_W-1:0] signed word offset
//   br_reg       in   [ADDR_W-1:0] register operand for BR / empty-stack RET
//   pc           out  [ADDR_W-1:0] current PC (registered)
//   pc_plus4     out  [ADDR_W-1:0] pc + 4 (combinational)
//   taken        out  current instruction redirects the PC (combinational)
//   link_data    out  [ADDR_W-1:0] X30 write-back value (registered)
//   link_we      out  one-cycle write pulse following a non-stalled BL
//   misalign_err out  sticky: a misaligned indirect target was taken
module pc_sequencer #(
    parameter int unsigned        ADDR_W       = 64,
    parameter logic [ADDR_W-1:0]  RESET_VECTOR = {ADDR_W{1'b0}},
    parameter int unsigned        OFFSET_W     = 26,
    parameter int unsigned        RAS_DEPTH    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic [2:0]          br_mode,
    input  logic                z_flag,
    input  logic [OFFSET_W-1:0] br_offset,
    input  logic [ADDR_W-1:0]   br_reg,
    output logic [ADDR_W-1:0]   pc,
    output logic [ADDR_W-1:0]   pc_plus4,
    output logic                taken,
    output logic [ADDR_W-1:0]   link_data,
    output logic                link_we,
    output logic                misalign_err
);

    localparam logic [2:0] MODE_B    = 3'd1;
    localparam logic [2:0] MODE_CBZ  = 3'd2;
    localparam logic [2:0] MODE_CBNZ = 3'd3;
    localparam logic [2:0] MODE_BR   = 3'd4;
    localparam logic [2:0] MODE_BL   = 3'd5;
`ifdef PC_RAS_EN
    localparam logic [2:0] MODE_RET  = 3'd6;
`endif
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(64'd4);

    // Stack depth must be a power of two so that pointer wrap is free.
    if ((RAS_DEPTH < 2) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("pc_sequencer: RAS_DEPTH must be a power of two and at least 2");
    end

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] link_data_q, link_data_d;
    logic              link_we_q, link_we_d;
    logic              misalign_q, misalign_d;

    logic [ADDR_W-1:0] pc_plus4_s;
    logic [ADDR_W-1:0] off_ext_s;
    logic [ADDR_W-1:0] rel_s;
    logic [ADDR_W-1:0] br_tgt_s;
    logic [ADDR_W-1:0] target_s;
    logic              taken_s;
    logic              mis_set_s;
    logic              push_s;

`ifdef PC_RAS_EN
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [PTR_W-1:0]  top_q, top_d;     // next free slot; top entry sits at top_q-1
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pop_s;
    logic              ras_we_s;
`endif

    assign pc_plus4_s = pc_q + PC_STEP;
    // Sign-extend the word offset; the size cast keeps signedness so it extends.
    assign off_ext_s  = ADDR_W'($signed(br_offset));
    assign rel_s      = pc_q + (off_ext_s << 2);
    assign br_tgt_s   = {br_reg[ADDR_W-1:2], 2'b00};

    // Branch decode: redirect decision, target and side-effect requests.
    always_comb begin
        taken_s   = 1'b0;
        target_s  = pc_plus4_s;
        mis_set_s = 1'b0;
        push_s    = 1'b0;
`ifdef PC_RAS_EN
        pop_s     = 1'b0;
`endif
        case (br_mode)
            MODE_B: begin
                taken_s  = 1'b1;
                target_s = rel_s;
            end
            MODE_CBZ: begin
                taken_s  = z_flag;
                target_s = rel_s;
            end
            MODE_CBNZ: begin
                taken_s  = !z_flag;
                target_s = rel_s;
            end
            MODE_BR: begin
                taken_s   = 1'b1;
                target_s  = br_tgt_s;
                mis_set_s = |br_reg[1:0];
            end
            MODE_BL: begin
                taken_s  = 1'b1;
                target_s = rel_s;
                push_s   = 1'b1;
            end
`ifdef PC_RAS_EN
            MODE_RET: begin
                taken_s = 1'b1;
                if (cnt_q != {CNT_W{1'b0}}) begin
                    target_s = ras_q[top_q - PTR_ONE];
                    pop_s    = 1'b1;
                end else begin
                    // Empty stack falls back to the register operand.
                    target_s  = br_tgt_s;
                    mis_set_s = |br_reg[1:0];
                end
            end
`endif
            default: begin
                taken_s  = 1'b0;
                target_s = pc_plus4_s;
            end
        endcase
    end

    // Next-state for PC, link register and sticky flag; stall freezes all.
    always_comb begin
        pc_d        = pc_q;
        link_data_d = link_data_q;
        link_we_d   = 1'b0;
        misalign_d  = misalign_q;
        if (!stall) begin
            pc_d       = taken_s ? target_s : pc_plus4_s;
            misalign_d = misalign_q | mis_set_s;
            if (push_s) begin
                link_data_d = pc_plus4_s;
                link_we_d   = 1'b1;
            end else begin
                link_data_d = link_data_q;
            end
        end else begin
            pc_d = pc_q;
        end
    end

    // Architectural state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_VECTOR;
            link_data_q <= {ADDR_W{1'b0}};
            link_we_q   <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            link_data_q <= link_data_d;
            link_we_q   <= link_we_d;
            misalign_q  <= misalign_d;
        end
    end

`ifdef PC_RAS_EN
    // Stack pointer/count update; a push when full overwrites the oldest slot.
    always_comb begin
        top_d    = top_q;
        cnt_d    = cnt_q;
        ras_we_s = 1'b0;
        if (!stall && push_s) begin
            ras_we_s = 1'b1;
            top_d    = top_q + PTR_ONE;
            cnt_d    = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_ONE;
        end else if (!stall && pop_s) begin
            top_d = top_q - PTR_ONE;
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            top_d = top_q;
        end
    end

    // Return-address stack storage and pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top_q <= {PTR_W{1'b0}};
            cnt_q <= {CNT_W{1'b0}};
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_q[i] <= {ADDR_W{1'b0}};
            end
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
            if (ras_we_s) begin
                ras_q[top_q] <= pc_plus4_s;
            end else begin
                ras_q[top_q] <= ras_q[top_q];
            end
        end
    end
`endif

    assign pc           = pc_q;
    assign pc_plus4     = pc_plus4_s;
    assign taken        = taken_s;
    assign link_data    = link_data_q;
    assign link_we      = link_we_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (default parameters).
module tb_pc_sequencer;

    localparam int RAS_DEPTH = 4;
`ifdef PC_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [2:0]  br_mode = 3'd0;
    logic        z_flag = 1'b0;
    logic [25:0] br_offset = 26'd0;
    logic [63:0] br_reg = 64'd0;
    logic [63:0] pc, pc_plus4, link_data;
    logic        taken, link_we, misalign_err;

    int total = 0;
    int bad   = 0;

    pc_sequencer #(.ADDR_W(64), .RESET_VECTOR(64'd0), .OFFSET_W(26), .RAS_DEPTH(RAS_DEPTH)) dut (
        .clk(clk), .reset(reset), .stall(stall), .br_mode(br_mode), .z_flag(z_flag),
        .br_offset(br_offset), .br_reg(br_reg), .pc(pc), .pc_plus4(pc_plus4),
        .taken(taken), .link_data(link_data), .link_we(link_we), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_pc = 64'd0, m_link = 64'd0;
    logic        m_we = 1'b0, m_mis = 1'b0;
    logic [63:0] m_ras [$];

    function automatic bit exp_taken(input logic [2:0] m, input logic z);
        case (m)
            3'd1, 3'd4, 3'd5: return 1'b1;
            3'd2:             return z;
            3'd3:             return !z;
            3'd6:             return RAS_EN;
            default:          return 1'b0;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin : model
        logic [63:0] rel, aligned, nxt;
        if (reset) begin
            m_pc <= 64'd0; m_link <= 64'd0; m_we <= 1'b0; m_mis <= 1'b0;
            m_ras.delete();
        end else if (stall) begin
            m_we <= 1'b0;
        end else begin
            rel     = m_pc + 64'($signed(br_offset)) * 64'd4;
            aligned = br_reg & ~64'd3;
            nxt     = m_pc + 64'd4;
            m_we   <= 1'b0;
            case (br_mode)
                3'd1: nxt = rel;
                3'd2: if (z_flag) nxt = rel;
                3'd3: if (!z_flag) nxt = rel;
                3'd4: begin
                    nxt = aligned;
                    if (br_reg[1:0] != 2'd0) m_mis <= 1'b1;
                end
                3'd5: begin
                    nxt = rel;
                    m_link <= m_pc + 64'd4;
                    m_we   <= 1'b1;
                    if (RAS_EN) begin
                        m_ras.push_back(m_pc + 64'd4);
                        if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
                    end
                end
                3'd6: if (RAS_EN) begin
                    if (m_ras.size() > 0) nxt = m_ras.pop_back();
                    else begin
                        nxt = aligned;
                        if (br_reg[1:0] != 2'd0) m_mis <= 1'b1;
                    end
                end
                default: ;
            endcase
            m_pc <= nxt;
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            check("cyc_pc",       pc,           m_pc);
            check("cyc_pc_plus4", pc_plus4,     m_pc + 64'd4);
            check("cyc_taken",    {63'd0, taken}, {63'd0, exp_taken(br_mode, z_flag)});
            check("cyc_link",     link_data,    m_link);
            check("cyc_link_we",  {63'd0, link_we}, {63'd0, m_we});
            check("cyc_mis",      {63'd0, misalign_err}, {63'd0, m_mis});
        end
    end

    // Apply one instruction for one clock, returning just after the edge.
    task automatic drive(input logic [2:0] m, input logic z, input logic [25:0] off,
                         input logic [63:0] r, input logic st);
        br_mode = m; z_flag = z; br_offset = off; br_reg = r; stall = st;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_pc", pc, 64'd0);
        check("rst_link", link_data, 64'd0);
        check("rst_we", {63'd0, link_we}, 64'd0);
        check("rst_mis", {63'd0, misalign_err}, 64'd0);

        for (int i = 1; i <= 4; i++) begin
            drive(3'd0, 1'b0, 26'd0, 64'd0, 1'b0);
            check("seq_pc", pc, 64'(4 * i));
            check("seq_we", {63'd0, link_we}, 64'd0);
        end

        drive(3'd1, 1'b0, 26'd12, 64'd0, 1'b0);      check("b_to_40", pc, 64'h40);
        drive(3'd2, 1'b1, 26'd3, 64'd0, 1'b0);       check("cbz_taken", pc, 64'h4C);
        drive(3'd2, 1'b0, 26'd3, 64'd0, 1'b0);       check("cbz_not", pc, 64'h50);
        drive(3'd3, 1'b0, -26'sd2, 64'd0, 1'b0);     check("cbnz_taken", pc, 64'h48);
        drive(3'd3, 1'b1, -26'sd2, 64'd0, 1'b0);     check("cbnz_not", pc, 64'h4C);
        drive(3'd7, 1'b0, 26'd5, 64'd0, 1'b0);       check("reserved", pc, 64'h50);
        drive(3'd1, 1'b0, 26'd44, 64'd0, 1'b0);      check("b_to_100", pc, 64'h100);

        drive(3'd5, 1'b0, 26'd16, 64'd0, 1'b0);
        check("bl_pc", pc, 64'h140);
        check("bl_link", link_data, 64'h104);
        check("bl_we", {63'd0, link_we}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            drive(3'd5, 1'b0, 26'd16, 64'd0, 1'b1);
            check("stall_pc", pc, 64'h140);
            check("stall_we", {63'd0, link_we}, 64'd0);
            check("stall_link", link_data, 64'h104);
        end
        drive(3'd5, 1'b0, 26'd1, 64'd0, 1'b0);
        check("bl2_link", link_data, 64'h144);
        check("bl2_we", {63'd0, link_we}, 64'd1);
        drive(3'd5, 1'b0, 26'd1, 64'd0, 1'b0);
        check("bl3_pc", pc, 64'h148);
        check("bl3_link", link_data, 64'h148);
        check("bl3_we", {63'd0, link_we}, 64'd1);

        drive(3'd4, 1'b0, 26'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        check("br_top", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("br_top_plus4", pc_plus4, 64'd0);
        drive(3'd0, 1'b0, 26'd0, 64'd0, 1'b0);       check("wrap_seq", pc, 64'd0);
        drive(3'd1, 1'b0, -26'sd1, 64'd0, 1'b0);     check("wrap_b", pc, 64'hFFFF_FFFF_FFFF_FFFC);

        drive(3'd4, 1'b0, 26'd0, 64'h203, 1'b1);
        check("stall_br_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("stall_br_mis", {63'd0, misalign_err}, 64'd0);
        drive(3'd4, 1'b0, 26'd0, 64'h203, 1'b0);
        check("br_mis_pc", pc, 64'h200);
        check("br_mis_flag", {63'd0, misalign_err}, 64'd1);
        drive(3'd0, 1'b0, 26'd0, 64'd0, 1'b0);
        check("mis_sticky", {63'd0, misalign_err}, 64'd1);
`ifndef PC_RAS_EN
        drive(3'd6, 1'b0, 26'd9, 64'h500, 1'b0);     check("mode6_seq", pc, 64'h208);
`endif
        drive(3'd4, 1'b0, 26'd0, 64'h300, 1'b0);     check("br_aligned", pc, 64'h300);
        drive(3'd5, 1'b0, 26'd4, 64'd0, 1'b0);
        check("bl4_pc", pc, 64'h310);
        check("bl4_link", link_data, 64'h304);

        // Asynchronous reset in the middle of a cycle.
        #2 reset = 1'b1;
        #1;
        check("async_pc", pc, 64'd0);
        check("async_pc_plus4", pc_plus4, 64'd4);
        check("async_link", link_data, 64'd0);
        check("async_we", {63'd0, link_we}, 64'd0);
        check("async_mis", {63'd0, misalign_err}, 64'd0);
        br_mode = 3'd0; stall = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        drive(3'd0, 1'b0, 26'd0, 64'd0, 1'b0);       check("post_rst_seq", pc, 64'd4);
        drive(3'd4, 1'b0, 26'd0, 64'd0, 1'b0);       check("br_zero", pc, 64'd0);

`ifdef PC_RAS_EN
        begin
            logic [63:0] rets [5];
            rets = '{64'h104, 64'hC4, 64'h84, 64'h44, 64'h300};
            for (int i = 0; i < 5; i++) begin
                drive(3'd5, 1'b0, 26'd16, 64'd0, 1'b0);
                check("ras_bl_pc", pc, 64'(64 * (i + 1)));
            end
            for (int i = 0; i < 5; i++) begin
                drive(3'd6, 1'b0, 26'd0, 64'h300, 1'b0);
                check("ras_ret_pc", pc, rets[i]);
            end
            check("ras_mis", {63'd0, misalign_err}, 64'd0);
        end
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
